// File: rtl/program_loader.sv
// Byte-serial bootloader: parses SYNC/COUNT/(HI,LO)*/CHK frames, writes 16-bit words
// into instruction memory and holds the CPU in reset until a load passes its checksum.
module program_loader #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [7:0]        SYNC_BYTE  = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
    S_CHECK = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t     state, next_state;
  logic [7:0] sum;
  logic [8:0] remaining;
  logic       accept;
  logic       is_sync;
  logic       chk_ok;
  logic [7:0] chk_sum;

  // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready;
  // rx_ready drops only for the single WRITE cycle, rx_valid may gap freely.
  assign rx_ready  = (state != S_WRITE);
  assign accept    = rx_valid && rx_ready;
  assign is_sync   = (rx_data == SYNC_BYTE);
  assign chk_sum   = sum + rx_data;
  assign chk_ok    = (chk_sum == 8'h00);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (accept && is_sync) next_state = S_COUNT;
      S_COUNT:               if (accept) next_state = S_HI;
      S_HI:                  if (accept) next_state = S_LO;
      S_LO:                  if (accept) next_state = S_WRITE;
      S_WRITE:               next_state = (remaining == 9'd1) ? S_CHECK : S_HI;
      S_CHECK:               if (accept) next_state = chk_ok ? S_DONE : S_ERR;
      default:               next_state = S_IDLE;
    endcase
  end

  // Write strobe is registered off the LO acceptance so it lines up with the WRITE state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= START_ADDR;
      imem_wdata <= 16'h0000;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      sum        <= 8'h00;
      remaining  <= 9'd0;
    end else begin
      imem_we <= (state == S_LO) && accept;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (accept && is_sync) begin
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_hold  <= 1'b1;
            sum       <= 8'h00;
            imem_addr <= START_ADDR;
          end
        end
        S_COUNT: begin
          if (accept) begin
            remaining <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            sum       <= sum + rx_data;
          end
        end
        S_HI: begin
          if (accept) begin
            imem_wdata[15:8] <= rx_data;
            sum              <= sum + rx_data;
          end
        end
        S_LO: begin
          if (accept) begin
            imem_wdata[7:0] <= rx_data;
            sum             <= sum + rx_data;
          end
        end
        S_WRITE: begin
          imem_addr <= imem_addr + 1'b1;
          remaining <= remaining - 9'd1;
        end
        S_CHECK: begin
          if (accept) begin
            if (chk_ok) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              error    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames driven byte by byte, memory writes
// collected by a monitor and compared against an expected {addr,data} queue.
module tb_program_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int ready_bad = 0;

  logic [23:0] exp_q[$];
  logic [23:0] wr_q[$];

  program_loader dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (reset && imem_we) wr_q.push_back({imem_addr, imem_wdata});
    if (reset && (rx_ready === imem_we)) ready_bad++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("ready_timeout", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic expect_write(input logic [7:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_wr_count"}, wr_q.size(), exp_q.size());
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_wr"}, {8'd0, wr_q[i]}, {8'd0, exp_q[i]});
    wr_q.delete();
    exp_q.delete();
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic h);
    check({tag, "_done"}, {31'd0, done}, {31'd0, d});
    check({tag, "_error"}, {31'd0, error}, {31'd0, e});
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, h});
  endtask

  initial begin
    logic [7:0] good_frame[7];
    good_frame = '{8'hA5, 8'h02, 8'hC1, 8'h05, 8'h20, 8'h10, 8'h08};

    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("rst_imem_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", {24'd0, imem_addr}, 32'h00);
    check("rst_wdata", {16'd0, imem_wdata}, 32'h0000);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    @(negedge clk);

    // good load
    send_byte(8'hA5, 0);
    check("good_hold_in_load", {31'd0, cpu_hold}, 32'd1);
    for (int i = 1; i < 7; i++) send_byte(good_frame[i], 0);
    expect_write(8'h00, 16'hC105);
    expect_write(8'h01, 16'h2010);
    compare_writes("good");
    check_status("good", 1'b1, 1'b0, 1'b0);
    check("good_addr_after", {24'd0, imem_addr}, 32'h02);

    // bad checksum, then a fresh good frame
    for (int i = 0; i < 6; i++) send_byte(good_frame[i], 0);
    send_byte(8'h09, 0);
    expect_write(8'h00, 16'hC105);
    expect_write(8'h01, 16'h2010);
    compare_writes("bad");
    check_status("bad", 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) send_byte(good_frame[i], 0);
    expect_write(8'h00, 16'hC105);
    expect_write(8'h01, 16'h2010);
    compare_writes("recover");
    check_status("recover", 1'b1, 1'b0, 1'b0);

    // garbage lead-in and random valid gaps
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_byte(8'h00, $urandom_range(0, 3));
    send_byte(8'hFF, $urandom_range(0, 3));
    send_byte(8'h3C, $urandom_range(0, 3));
    check("garbage_idle", {29'd0, dbg_state}, 32'd0);
    for (int i = 0; i < 7; i++) send_byte(good_frame[i], $urandom_range(0, 3));
    expect_write(8'h00, 16'hC105);
    expect_write(8'h01, 16'h2010);
    compare_writes("gaps");
    check_status("gaps", 1'b1, 1'b0, 1'b0);

    // COUNT=0 -> 256 words, data = address; low bytes sum to 0x80 so CHK = 0x80
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'h00, 0);
      send_byte(8'(i), 0);
      expect_write(8'(i), 16'(i));
    end
    send_byte(8'h80, 0);
    compare_writes("full");
    check_status("full", 1'b1, 1'b0, 1'b0);
    check("full_addr_wrap", {24'd0, imem_addr}, 32'h00);

    // reload while in DONE
    send_byte(8'hA5, 0);
    check_status("reload_start", 1'b0, 1'b0, 1'b1);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    check("reload_hold_mid", {31'd0, cpu_hold}, 32'd1);
    send_byte(8'hB9, 0);
    expect_write(8'h00, 16'h1234);
    compare_writes("reload");
    check_status("reload", 1'b1, 1'b0, 1'b0);
    check("reload_addr", {24'd0, imem_addr}, 32'h01);

    // reset mid-frame after the HI byte of the first word
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h77, 0);
    reset = 1'b0;
    #1;
    check("midrst_we", {31'd0, imem_we}, 32'd0);
    check("midrst_state", {29'd0, dbg_state}, 32'd0);
    check_status("midrst", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_byte(8'h01, 0);
    check("midrst_ignore", {29'd0, dbg_state}, 32'd0);
    compare_writes("midrst");
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'hB9, 0);
    expect_write(8'h00, 16'h1234);
    compare_writes("after_rst");
    check_status("after_rst", 1'b1, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("ready_only_low_in_write", ready_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
